command_dispatcher: RTL

- Sits between the trace parser and the split L1 caches (instruction and data).
- Captures each parser instruction on the rising edge of instruction_ready and queues it in a small FIFO.
- Decodes each command, then issues it to the I-cache, the D-cache or both, using a req/ack handshake per cache.
- Because capture is edge-based, two identical back-to-back trace lines count as two instructions.

---
 rtl/cache_cmd_pkg.sv | 39 +++
 rtl/cmd_fifo.sv | 60 ++++++
 rtl/command_dispatcher.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/cache_cmd_pkg.sv
// Command encodings, routing targets and FIFO entry layout shared between the
// dispatcher and the L1 caches.
package cache_cmd_pkg;

  typedef enum logic [3:0] {
    READ_D     = 4'd0,
    WRITE_D    = 4'd1,
    FETCH_I    = 4'd2,
    INVALIDATE = 4'd3,
    SNOOP      = 4'd4,
    CLEAR      = 4'd8,
    PRINT      = 4'd9
  } cmd_e;

  typedef enum logic [1:0] {
    TGT_NONE,
    TGT_I,
    TGT_D,
    TGT_BOTH
  } target_e;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] addr;
  } fifo_entry_t;

  // Stand-in code for a command whose upper bits were non-zero; it routes to TGT_NONE.
  localparam logic [3:0] CMD_BAD = 4'hF;

  function automatic target_e route(input logic [3:0] cmd);
    case (cmd)
      READ_D, WRITE_D, SNOOP:    route = TGT_D;
      FETCH_I:                   route = TGT_I;
      INVALIDATE, CLEAR, PRINT:  route = TGT_BOTH;
      default:                   route = TGT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO of decoded parser commands; pointers carry an extra wrap bit
// so full and empty can be told apart.
module cmd_fifo
  import cache_cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  fifo_entry_t push_data,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output fifo_entry_t pop_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  fifo_entry_t mem_q [DEPTH];
  fifo_entry_t mem_d [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push;
  logic        do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/command_dispatcher.sv
// Captures parser instructions on the rising edge of instruction_ready, queues
// them and issues each to the I-cache, D-cache or both over req/ack handshakes.
//
//   state       | meaning
//   ------------+-------------------------------------------------------
//   S_IDLE      | no command in flight; pops the FIFO when it is non-empty
//   S_ISSUE     | single-target command waiting for its cache ack
//   S_WAIT_BOTH | broadcast command waiting for both acks, in any order
module command_dispatcher
  import cache_cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      command,
  input  logic [31:0]      address,
  input  logic             instruction_ready,
  output logic             icache_req,
  output logic [3:0]       icache_cmd,
  output logic [31:0]      icache_addr,
  input  logic             icache_ack,
  output logic             dcache_req,
  output logic [3:0]       dcache_cmd,
  output logic [31:0]      dcache_addr,
  input  logic             dcache_ack,
  output logic             busy,
  output logic             overflow,
  output logic             bad_cmd,
  output logic [CNT_W-1:0] dispatched_count,
  output logic [15:0]      dropped_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BOTH
  } state_e;

  state_e           state_q, state_d;
  logic             prev_ready_q;
  logic             ireq_q, ireq_d, dreq_q, dreq_d;
  logic [3:0]       icmd_q, icmd_d, dcmd_q, dcmd_d;
  logic [31:0]      iaddr_q, iaddr_d, daddr_q, daddr_d;
  logic             bad_q, bad_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] disp_q, disp_d;
  logic [15:0]      drop_q, drop_d;
  logic [16:0]      drop_sum;
  logic             done;

  logic        capture;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic        ovf_drop;
  fifo_entry_t push_entry;
  fifo_entry_t head;
  target_e     head_tgt;

  assign capture        = instruction_ready && !prev_ready_q;
  assign push_entry.cmd  = (command[31:4] != 28'd0) ? CMD_BAD : command[3:0];
  assign push_entry.addr = address;
  assign fifo_pop       = (state_q == S_IDLE) && !fifo_empty;
  assign ovf_drop       = capture && fifo_full && !fifo_pop;
  assign head_tgt       = route(head.cmd);

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (capture),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .pop_data  (head)
  );

  always_comb begin
    state_d = state_q;
    ireq_d  = ireq_q;
    dreq_d  = dreq_q;
    icmd_d  = icmd_q;
    iaddr_d = iaddr_q;
    dcmd_d  = dcmd_q;
    daddr_d = daddr_q;
    bad_d   = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fifo_pop) begin
          if (head_tgt == TGT_I || head_tgt == TGT_BOTH) begin
            ireq_d  = 1'b1;
            icmd_d  = head.cmd;
            iaddr_d = head.addr;
          end
          if (head_tgt == TGT_D || head_tgt == TGT_BOTH) begin
            dreq_d  = 1'b1;
            dcmd_d  = head.cmd;
            daddr_d = head.addr;
          end
          case (head_tgt)
            TGT_I, TGT_D: state_d = S_ISSUE;
            TGT_BOTH:     state_d = S_WAIT_BOTH;
            default:      bad_d   = 1'b1;
          endcase
        end
      end
      S_ISSUE, S_WAIT_BOTH: begin
        // Each request retires on its own ack; an ack with req low has no effect.
        ireq_d = ireq_q && !icache_ack;
        dreq_d = dreq_q && !dcache_ack;
        if (!ireq_d && !dreq_d) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ovf_d    = ovf_q || ovf_drop;
    disp_d   = disp_q + {{(CNT_W-1){1'b0}}, done};
    drop_sum = {1'b0, drop_q} + {15'd0, ovf_drop} + {15'd0, bad_d};
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      prev_ready_q <= 1'b0;
      ireq_q       <= 1'b0;
      dreq_q       <= 1'b0;
      icmd_q       <= '0;
      iaddr_q      <= '0;
      dcmd_q       <= '0;
      daddr_q      <= '0;
      bad_q        <= 1'b0;
      ovf_q        <= 1'b0;
      disp_q       <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      prev_ready_q <= instruction_ready;
      ireq_q       <= ireq_d;
      dreq_q       <= dreq_d;
      icmd_q       <= icmd_d;
      iaddr_q      <= iaddr_d;
      dcmd_q       <= dcmd_d;
      daddr_q      <= daddr_d;
      bad_q        <= bad_d;
      ovf_q        <= ovf_d;
      disp_q       <= disp_d;
      drop_q       <= drop_d;
    end
  end

  assign icache_req       = ireq_q;
  assign icache_cmd       = icmd_q;
  assign icache_addr      = iaddr_q;
  assign dcache_req       = dreq_q;
  assign dcache_cmd       = dcmd_q;
  assign dcache_addr      = daddr_q;
  assign busy             = !fifo_empty || (state_q != S_IDLE);
  assign overflow         = ovf_q;
  assign bad_cmd          = bad_q;
  assign dispatched_count = disp_q;
  assign dropped_count    = drop_q;

endmodule
